// File: rtl/bicubic_window_stream_buffer.sv
// bicubic_window_stream_buffer: stores NxN multi-channel windows and replays each as N column/row beats with frame markers
module bicubic_window_stream_buffer #(
  parameter int N           = 4,
  parameter int CH          = 3,
  parameter int PW          = 8,
  parameter int DEPTH       = 512,
  parameter int READY_LEVEL = 320,
  parameter int CW          = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_mode,
  input  logic [CW-1:0]          i_frame_w,
  input  logic [CW-1:0]          i_frame_h,
  input  logic [CH*N*N*PW-1:0]   s_axis_tdata,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  output logic [N*CH*PW-1:0]     m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   o_eof,
  output logic                   o_load_ready,
  output logic [$clog2(DEPTH):0] o_level,
  output logic                   o_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int WW = CH * N * N * PW;
  localparam int NB = (N > 1) ? $clog2(N) : 1;

  logic [WW-1:0]     mem_q [DEPTH];
  logic [LW-1:0]     wr_q, rd_q, level_q, level_d;
  logic [WW-1:0]     pre_q, win_q;
  logic              pre_v_q, win_v_q;
  logic              rdy_q, ldr_q, ovf_q;
  logic [NB-1:0]     beat_q;
  logic [CW-1:0]     wx_q, wy_q, w_q, h_q;
  logic              mode_q;
  logic [CW-1:0]     w_in, h_in, w_eff, h_eff;
  logic              push, hs, last_b, last_hs, win_ld, pre_ld;
  logic              sof, eol, eof, mode_eff;
  logic [N*CH*PW-1:0] beat_data;

  assign push     = s_axis_tvalid & rdy_q;
  assign hs       = win_v_q & m_axis_tready;
  assign last_b   = beat_q == NB'(N - 1);
  assign last_hs  = hs & last_b;
  // The prefetch register stands in for a registered RAM read; the window
  // register holds the window being serialised and refills on its final beat.
  assign win_ld   = pre_v_q & (~win_v_q | last_hs);
  assign pre_ld   = (wr_q != rd_q) & (~pre_v_q | win_ld);
  assign level_d  = level_q + LW'(push) - LW'(last_hs);
  assign sof      = beat_q == '0 && wx_q == '0 && wy_q == '0;
  assign w_in     = (i_frame_w == '0) ? CW'(1) : i_frame_w;
  assign h_in     = (i_frame_h == '0) ? CW'(1) : i_frame_h;
  // Live configuration applies until the SOF beat is taken, then the held copy.
  assign mode_eff = sof ? i_mode : mode_q;
  assign w_eff    = sof ? w_in : w_q;
  assign h_eff    = sof ? h_in : h_q;
  assign eol      = last_b && wx_q == w_eff - 1'b1;
  assign eof      = eol && wy_q == h_eff - 1'b1;

  // Select column (mode 0) or row (mode 1) beat_q of the current window.
  always_comb begin
    beat_data = '0;
    for (int i = 0; i < N; i++)
      for (int c = 0; c < CH; c++)
        beat_data[(i*CH+c)*PW +: PW] =
          win_q[c*N*N*PW + (N*N-1-(mode_eff ? int'(beat_q)*N+i : i*N+int'(beat_q)))*PW +: PW];
  end

  // Window storage; contents need no reset since pointers define validity.
  always_ff @(posedge i_clk)
    if (push) mem_q[wr_q[AW-1:0]] <= s_axis_tdata;

  // Pointers, prefetch/serialise pipeline, level and status flags.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      pre_q   <= '0;
      win_q   <= '0;
      pre_v_q <= 1'b0;
      win_v_q <= 1'b0;
      level_q <= '0;
      rdy_q   <= 1'b0;
      ldr_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (push) wr_q <= wr_q + 1'b1;
      if (pre_ld) begin
        rd_q  <= rd_q + 1'b1;
        pre_q <= mem_q[rd_q[AW-1:0]];
      end
      if (win_ld) win_q <= pre_q;
      pre_v_q <= pre_ld | (pre_v_q & ~win_ld);
      win_v_q <= win_ld | (win_v_q & ~last_hs);
      level_q <= level_d;
      rdy_q   <= level_d < LW'(DEPTH);
      ldr_q   <= level_q <= LW'(READY_LEVEL);
      ovf_q   <= ovf_q | (s_axis_tvalid & ~rdy_q);
    end
  end

  // Beat / window / line counters and per-frame configuration capture.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      beat_q <= '0;
      wx_q   <= '0;
      wy_q   <= '0;
      mode_q <= 1'b0;
      w_q    <= CW'(1);
      h_q    <= CW'(1);
    end else if (hs) begin
      beat_q <= last_b ? '0 : beat_q + 1'b1;
      if (last_b) wx_q <= eol ? '0 : wx_q + 1'b1;
      if (eol) wy_q <= eof ? '0 : wy_q + 1'b1;
      if (sof) begin
        mode_q <= i_mode;
        w_q    <= w_in;
        h_q    <= h_in;
      end
    end
  end

  assign s_axis_tready = rdy_q;
  assign m_axis_tvalid = win_v_q;
  assign m_axis_tdata  = beat_data;
  assign m_axis_tuser  = win_v_q & sof;
  assign m_axis_tlast  = win_v_q & eol;
  assign o_eof         = win_v_q & eof;
  assign o_load_ready  = ldr_q;
  assign o_level       = level_q;
  assign o_overflow    = ovf_q;
endmodule

// File: tb/tb_bicubic_window_stream_buffer.sv
// tb_bicubic_window_stream_buffer: directed checks of window replay, framing, flow control and reset
module tb_bicubic_window_stream_buffer;
  logic         i_clk = 1'b0;
  logic         i_rstn = 1'b1;
  logic         i_mode = 1'b0;
  logic [11:0]  i_frame_w = 12'd1;
  logic [11:0]  i_frame_h = 12'd1;
  logic [383:0] s_axis_tdata = '0;
  logic         s_axis_tvalid = 1'b0;
  logic         s_axis_tready;
  logic [95:0]  m_axis_tdata;
  logic         m_axis_tvalid;
  logic         m_axis_tready = 1'b0;
  logic         m_axis_tlast, m_axis_tuser, o_eof, o_load_ready, o_overflow;
  logic [3:0]   o_level;

  int n_chk = 0, n_err = 0;
  int idx = 0, cyc = 0, first_cyc = 0, last_cyc = 0, tw = 1, th = 1;
  logic tmode = 1'b0;
  logic stall = 1'b0;
  logic [95:0] pd;
  logic [2:0]  pf;
  logic [95:0] exp_q[$];
  logic        tb_done;

  bicubic_window_stream_buffer #(.N(4), .CH(3), .PW(8), .DEPTH(8), .READY_LEVEL(5), .CW(12)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_mode(i_mode), .i_frame_w(i_frame_w), .i_frame_h(i_frame_h),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .o_eof(o_eof),
    .o_load_ready(o_load_ready), .o_level(o_level), .o_overflow(o_overflow));

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pix(input int s, input int r, input int c, input int ch);
    return 8'(s * 53 + 16 * r + 4 * c + ch);
  endfunction

  function automatic logic [383:0] pack(input int s);
    logic [383:0] v = '0;
    for (int ch = 0; ch < 3; ch++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          v[ch*128 + (15-(r*4+c))*8 +: 8] = pix(s, r, c, ch);
    return v;
  endfunction

  function automatic logic [95:0] beat(input int s, input int j, input logic m);
    logic [95:0] b = '0;
    for (int i = 0; i < 4; i++)
      for (int ch = 0; ch < 3; ch++)
        b[(i*3+ch)*8 +: 8] = m ? pix(s, j, i, ch) : pix(s, i, j, ch);
    return b;
  endfunction

  // Scoreboard: checks every accepted beat, framing flags by global beat index, and AXI hold under stall.
  always @(negedge i_clk) begin
    if (!i_rstn) begin
      idx = 0;
      stall = 1'b0;
      exp_q.delete();
    end else begin
      if (stall) begin
        check("hold_valid", m_axis_tvalid, 1);
        check("hold_data", m_axis_tdata, pd);
        check("hold_flags", {m_axis_tuser, m_axis_tlast, o_eof}, pf);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        check("pending_beats", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) check("beat_data", m_axis_tdata, exp_q.pop_front());
        check("tuser", m_axis_tuser, idx % (4*tw*th) == 0);
        check("tlast", m_axis_tlast, idx % (4*tw) == 4*tw-1);
        check("eof", o_eof, idx % (4*tw*th) == 4*tw*th-1);
        if (idx == 0) first_cyc = cyc;
        last_cyc = cyc;
        idx++;
      end
      stall = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pf = {m_axis_tuser, m_axis_tlast, o_eof};
    end
  end

  task automatic rst_dut();
    i_rstn = 1'b0;
    s_axis_tvalid = 1'b0;
    #1;
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_level", o_level, 0);
    check("rst_outs", {s_axis_tready, m_axis_tuser, m_axis_tlast, o_eof, o_load_ready, o_overflow, m_axis_tdata}, 0);
    repeat (2) @(posedge i_clk);
    #1;
    i_rstn = 1'b1;
    @(posedge i_clk);
    #1;
  endtask

  task automatic push(input int s);
    int n = 0;
    s_axis_tdata = pack(s);
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 2000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("push_ready", s_axis_tready, 1);
    for (int j = 0; j < 4; j++) exp_q.push_back(beat(s, j, tmode));
    @(posedge i_clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_valid();
    int n = 0;
    while (!m_axis_tvalid && n < 50) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check("tvalid_seen", m_axis_tvalid, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    #3;
    // Single window, column mode, zero frame size treated as 1x1, with latency.
    rst_dut();
    i_mode = 1'b0; tmode = 1'b0; i_frame_w = 12'd0; i_frame_h = 12'd0; tw = 1; th = 1;
    m_axis_tready = 1'b0;
    push(0);
    s_axis_tvalid = 1'b0;
    check("lat_t", m_axis_tvalid, 0);
    check("level_one", o_level, 1);
    @(posedge i_clk); #1;
    check("lat_t1", m_axis_tvalid, 0);
    @(posedge i_clk); #1;
    check("lat_t2", m_axis_tvalid, 1);
    check("col0_data", m_axis_tdata, 96'h323130_222120_121110_020100);
    check("col0_tuser", m_axis_tuser, 1);
    check("col0_tlast", m_axis_tlast, 0);
    m_axis_tready = 1'b1;
    drain();
    @(posedge i_clk); #1;
    check("idle_level", o_level, 0);
    check("idle_valid", m_axis_tvalid, 0);

    // Same window, row mode.
    rst_dut();
    i_mode = 1'b1; tmode = 1'b1; i_frame_w = 12'd1; i_frame_h = 12'd1;
    m_axis_tready = 1'b0;
    push(0);
    s_axis_tvalid = 1'b0;
    wait_valid();
    check("row0_data", m_axis_tdata, 96'h0e0d0c_0a0908_060504_020100);
    m_axis_tready = 1'b1;
    drain();

    // 3x2 frame, back-to-back windows, gapless output.
    rst_dut();
    i_mode = 1'b0; tmode = 1'b0; i_frame_w = 12'd3; i_frame_h = 12'd2; tw = 3; th = 2;
    m_axis_tready = 1'b1;
    for (int k = 0; k < 6; k++) push(10 + k);
    s_axis_tvalid = 1'b0;
    drain();
    check("beats_frame", idx, 24);
    check("gapless_span", last_cyc - first_cyc, 23);

    // 100 windows, 5x2 frames, row mode, random output stalls.
    rst_dut();
    i_mode = 1'b1; tmode = 1'b1; i_frame_w = 12'd5; i_frame_h = 12'd2; tw = 5; th = 2;
    tb_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 100; k++) push(200 + k);
        s_axis_tvalid = 1'b0;
        tb_done = 1'b1;
      end
      begin
        while (!tb_done) begin
          m_axis_tready = 1'($urandom_range(0, 1));
          @(posedge i_clk); #1;
        end
        m_axis_tready = 1'b1;
      end
    join
    drain();
    check("beats_random", idx, 400);

    // Mid-frame reset after beat 5, then a clean restart.
    rst_dut();
    i_mode = 1'b0; tmode = 1'b0; i_frame_w = 12'd2; i_frame_h = 12'd1; tw = 2; th = 1;
    m_axis_tready = 1'b1;
    push(50);
    push(51);
    s_axis_tvalid = 1'b0;
    for (int n = 0; n < 100 && idx < 6; n++) begin
      @(posedge i_clk); #1;
    end
    check("reached_beat5", idx, 6);
    rst_dut();
    i_frame_w = 12'd1; tw = 1; th = 1;
    m_axis_tready = 1'b0;
    push(60);
    s_axis_tvalid = 1'b0;
    wait_valid();
    check("restart_tuser", m_axis_tuser, 1);
    check("restart_data", m_axis_tdata, beat(60, 0, 1'b0));
    m_axis_tready = 1'b1;
    drain();

    // Fill to capacity with output stalled, overflow attempts, watermark.
    rst_dut();
    i_mode = 1'b0; tmode = 1'b0; i_frame_w = 12'd1; i_frame_h = 12'd1; tw = 1; th = 1;
    m_axis_tready = 1'b0;
    begin
      int acc = 0;
      s_axis_tvalid = 1'b1;
      for (int a = 0; a < 10; a++) begin
        s_axis_tdata = pack(100 + a);
        if (s_axis_tready) begin
          acc++;
          for (int j = 0; j < 4; j++) exp_q.push_back(beat(100 + a, j, 1'b0));
        end
        @(posedge i_clk); #1;
        if (a == 4) check("ldr_at5", o_load_ready, 1);
        if (a == 5) begin
          check("level_six", o_level, 6);
          check("ldr_lags", o_load_ready, 1);
        end
        if (a == 6) check("ldr_fell", o_load_ready, 0);
        if (a == 7) begin
          check("full_tready", s_axis_tready, 0);
          check("level_full", o_level, 8);
          check("ovf_before", o_overflow, 0);
        end
        if (a == 8) check("ovf_set", o_overflow, 1);
      end
      s_axis_tvalid = 1'b0;
      check("accepted", acc, 8);
      check("level_held", o_level, 8);
    end
    m_axis_tready = 1'b1;
    drain();
    @(posedge i_clk); #1;
    check("drained_level", o_level, 0);
    check("drained_ldr", o_load_ready, 1);
    check("drained_tready", s_axis_tready, 1);
    check("ovf_sticky", o_overflow, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
